sb_arbiter: RTL

//  Two-master SB bus arbiter. Sits directly upstream of each SB master and drives its sb_grant_mX.

---
 rtl/sb_arbiter_if.sv | 30 +++
 rtl/sb_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sb_arbiter_if.sv
// sb_arbiter_if: request/grant and slave-response signals between SB masters, slave and arbiter.
// The arbiter connects through the slave modport; master-side logic uses the master modport.
interface sb_arbiter_if;
   logic       sb_busreq_m1;
   logic       sb_busreq_m2;
   logic       sb_lock_m1;
   logic       sb_lock_m2;
   logic [1:0] sb_trans_m1;
   logic [1:0] sb_trans_m2;
   logic       sb_ready;
   logic [1:0] sb_resp;
   logic [1:0] sb_split_unmask;
   logic       sb_grant_m1;
   logic       sb_grant_m2;
   logic [1:0] sb_master_sel;
   logic [1:0] sb_data_sel;
   logic       sb_mastlock;

   modport slave (
      input  sb_busreq_m1, sb_busreq_m2, sb_lock_m1, sb_lock_m2,
      input  sb_trans_m1, sb_trans_m2, sb_ready, sb_resp, sb_split_unmask,
      output sb_grant_m1, sb_grant_m2, sb_master_sel, sb_data_sel, sb_mastlock
   );

   modport master (
      output sb_busreq_m1, sb_busreq_m2, sb_lock_m1, sb_lock_m2,
      output sb_trans_m1, sb_trans_m2, sb_ready, sb_resp, sb_split_unmask,
      input  sb_grant_m1, sb_grant_m2, sb_master_sel, sb_data_sel, sb_mastlock
   );
endinterface

// File: rtl/sb_arbiter.sv
// sb_arbiter: two-master SB arbiter with round-robin ties, locked holds and SPLIT masking.
// Define SB_ARB_TIMEOUT_EN to enable hold-timeout preemption of unlocked owners.
module sb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned TMR_WIDTH      = 5
) (
   input logic         sb_clk,
   input logic         sb_resetn,
   sb_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_M1   = 2'd1,
      ARB_M2   = 2'd2
   } arb_state_e;

   localparam logic [1:0] RESP_SPLIT = 2'd3;
   localparam logic [1:0] TRANS_BUSY = 2'd1;
   localparam logic [1:0] TRANS_SEQ  = 2'd3;

   arb_state_e state_q, state_d;
   logic [1:0] data_sel_q, data_sel_d;
   logic [1:0] mask_q, mask_d;
   logic       last_m2_q, last_m2_d;
   logic       mastlock_q, mastlock_d;
   logic [1:0] split_set;
   logic [1:0] elig;
   logic       preempt;

   // SPLIT targets the data-phase owner, not necessarily the current grant holder
   always_comb begin
      split_set = '0;
      if (bus.sb_resp == RESP_SPLIT) begin
         if (data_sel_q == 2'd1) split_set[0] = 1'b1;
         else if (data_sel_q == 2'd2) split_set[1] = 1'b1;
      end
   end

   assign elig   = {bus.sb_busreq_m2, bus.sb_busreq_m1} & ~(mask_q | split_set);
   assign mask_d = (mask_q & ~bus.sb_split_unmask) | split_set;

`ifdef SB_ARB_TIMEOUT_EN
   logic [TMR_WIDTH-1:0] cnt_q, cnt_d;
   logic                 other_elig;
   logic                 own_lock;
   logic [1:0]           own_trans;

   always_comb begin
      other_elig = 1'b0;
      own_lock   = 1'b0;
      own_trans  = '0;
      if (state_q == ARB_M1) begin
         other_elig = elig[1];
         own_lock   = bus.sb_lock_m1;
         own_trans  = bus.sb_trans_m1;
      end else if (state_q == ARB_M2) begin
         other_elig = elig[0];
         own_lock   = bus.sb_lock_m2;
         own_trans  = bus.sb_trans_m2;
      end
      preempt = (cnt_q == TMR_WIDTH'(TIMEOUT_CYCLES)) && !own_lock && other_elig &&
                (own_trans != TRANS_SEQ) && (own_trans != TRANS_BUSY);
      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = '0;
      else if (other_elig && (cnt_q != TMR_WIDTH'(TIMEOUT_CYCLES))) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge sb_clk or negedge sb_resetn) begin
      if (!sb_resetn) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
`else
   logic                 unused_trans;
   logic [TMR_WIDTH-1:0] unused_tmr;
   assign preempt      = 1'b0;
   assign unused_trans = ^{bus.sb_trans_m1, bus.sb_trans_m2};
   assign unused_tmr   = TMR_WIDTH'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (&elig)        state_d = last_m2_q ? ARB_M1 : ARB_M2;
            else if (elig[0]) state_d = ARB_M1;
            else if (elig[1]) state_d = ARB_M2;
         end
         ARB_M1: begin
            if (split_set[0]) state_d = elig[1] ? ARB_M2 : ARB_IDLE;
            else if (bus.sb_ready) begin
               if (!bus.sb_busreq_m1) state_d = elig[1] ? ARB_M2 : ARB_IDLE;
               else if (preempt)      state_d = ARB_M2;
            end
         end
         ARB_M2: begin
            if (split_set[1]) state_d = elig[0] ? ARB_M1 : ARB_IDLE;
            else if (bus.sb_ready) begin
               if (!bus.sb_busreq_m2) state_d = elig[0] ? ARB_M1 : ARB_IDLE;
               else if (preempt)      state_d = ARB_M1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      last_m2_d = last_m2_q;
      if (state_d == ARB_M1)      last_m2_d = 1'b0;
      else if (state_d == ARB_M2) last_m2_d = 1'b1;

      mastlock_d = 1'b0;
      if (state_d == ARB_M1)      mastlock_d = bus.sb_lock_m1;
      else if (state_d == ARB_M2) mastlock_d = bus.sb_lock_m2;

      data_sel_d = bus.sb_ready ? state_q : data_sel_q;
   end

   always_ff @(posedge sb_clk or negedge sb_resetn) begin
      if (!sb_resetn) begin
         state_q    <= ARB_IDLE;
         data_sel_q <= '0;
         mask_q     <= '0;
         last_m2_q  <= 1'b1;
         mastlock_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_sel_q <= data_sel_d;
         mask_q     <= mask_d;
         last_m2_q  <= last_m2_d;
         mastlock_q <= mastlock_d;
      end
   end

   assign bus.sb_grant_m1   = (state_q == ARB_M1);
   assign bus.sb_grant_m2   = (state_q == ARB_M2);
   assign bus.sb_master_sel = state_q;
   assign bus.sb_data_sel   = data_sel_q;
   assign bus.sb_mastlock   = mastlock_q;
endmodule
